// File: rtl/rggen_apb_bridge.sv
// rggen_apb_bridge: rggen bus initiator to APB4 master bridge (SETUP/ACCESS).
// Define RGGEN_APB_BRIDGE_TIMEOUT_EN to abort ACCESS phases that stall too long.
module rggen_apb_bridge #(
    parameter int                   ADDRESS_WIDTH  = 8,
    parameter int                   BUS_WIDTH      = 32,
    parameter logic [2:0]           PPROT          = 3'b000,
    parameter int                   TIMEOUT_CYCLES = 256,
    parameter logic [BUS_WIDTH-1:0] ERROR_DATA     = '0
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_bus_valid,
    input  logic [ADDRESS_WIDTH-1:0] i_bus_address,
    input  logic                     i_bus_write,
    input  logic [BUS_WIDTH-1:0]     i_bus_write_data,
    input  logic [BUS_WIDTH/8-1:0]   i_bus_strobe,
    output logic                     o_bus_ready,
    output logic [1:0]               o_bus_status,
    output logic [BUS_WIDTH-1:0]     o_bus_read_data,
    output logic                     o_psel,
    output logic                     o_penable,
    output logic                     o_pwrite,
    output logic [ADDRESS_WIDTH-1:0] o_paddr,
    output logic [2:0]               o_pprot,
    output logic [BUS_WIDTH-1:0]     o_pwdata,
    output logic [BUS_WIDTH/8-1:0]   o_pstrb,
    input  logic                     i_pready,
    input  logic [BUS_WIDTH-1:0]     i_prdata,
    input  logic                     i_pslverr
);
    localparam int STRB_WIDTH = BUS_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_e;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 1..65535");
    end

    state_e                   state_q, state_d;
    logic                     psel_q, psel_d;
    logic                     penable_q, penable_d;
    logic                     pwrite_q, pwrite_d;
    logic [ADDRESS_WIDTH-1:0] paddr_q, paddr_d;
    logic [BUS_WIDTH-1:0]     pwdata_q, pwdata_d;
    logic [STRB_WIDTH-1:0]    pstrb_q, pstrb_d;
    logic                     timeout;
    logic                     done;

`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (state_q == IDLE && i_bus_valid) begin
            count_d = '0;
        end else if (state_q == ACCESS && !i_pready) begin
            count_d = count_q + 16'd1;
        end
    end

    // A completer ready in the same cycle beats the abort.
    assign timeout = (state_q == ACCESS) && !i_pready &&
                     (count_q == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign done = (state_q == ACCESS) && (i_pready || timeout);

    always_comb begin
        state_d   = state_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        unique case (state_q)
            IDLE: begin
                if (i_bus_valid) begin
                    state_d   = SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = i_bus_write;
                    paddr_d   = i_bus_address;
                    pwdata_d  = i_bus_write ? i_bus_write_data : '0;
                    pstrb_d   = i_bus_write ? i_bus_strobe : '0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (done) begin
                    state_d   = IDLE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
        end else begin
            state_q   <= state_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
        end
    end

    always_comb begin
        o_bus_ready     = done;
        o_bus_status    = 2'b00;
        o_bus_read_data = '0;
        if (timeout) begin
            o_bus_status    = 2'b10;
            o_bus_read_data = ERROR_DATA;
        end else if (done) begin
            o_bus_status    = i_pslverr ? 2'b10 : 2'b00;
            o_bus_read_data = pwrite_q ? '0 : i_prdata;
        end
    end

    assign o_psel    = psel_q;
    assign o_penable = penable_q;
    assign o_pwrite  = pwrite_q;
    assign o_paddr   = paddr_q;
    assign o_pprot   = PPROT;
    assign o_pwdata  = pwdata_q;
    assign o_pstrb   = pstrb_q;

endmodule

// File: tb/tb_rggen_apb_bridge.sv
// tb_rggen_apb_bridge: directed and randomized APB bridge transfers against
// a word-memory completer and a transaction-level reference memory.
module tb_rggen_apb_bridge;
    localparam int          AW   = 8;
    localparam int          BW   = 32;
    localparam int          SW   = 4;
    localparam logic [2:0]  PP   = 3'b101;
    localparam int          TO   = 4;
    localparam logic [31:0] ERRD = 32'hBAD0_BAD0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          bus_valid = 1'b0;
    logic [AW-1:0] bus_addr = '0;
    logic          bus_write = 1'b0;
    logic [BW-1:0] bus_wdata = '0;
    logic [SW-1:0] bus_strb = '0;
    logic          bus_ready;
    logic [1:0]    bus_status;
    logic [BW-1:0] bus_rdata;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [2:0]    pprot;
    logic [BW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic          pready = 1'b0;
    logic [BW-1:0] prdata = '0;
    logic          pslverr = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] ref_mem [256];
    logic [31:0] cpl_mem [256];

    always #5 clk = ~clk;

    rggen_apb_bridge #(
        .ADDRESS_WIDTH  (AW),
        .BUS_WIDTH      (BW),
        .PPROT          (PP),
        .TIMEOUT_CYCLES (TO),
        .ERROR_DATA     (ERRD)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_bus_valid      (bus_valid),
        .i_bus_address    (bus_addr),
        .i_bus_write      (bus_write),
        .i_bus_write_data (bus_wdata),
        .i_bus_strobe     (bus_strb),
        .o_bus_ready      (bus_ready),
        .o_bus_status     (bus_status),
        .o_bus_read_data  (bus_rdata),
        .o_psel           (psel),
        .o_penable        (penable),
        .o_pwrite         (pwrite),
        .o_paddr          (paddr),
        .o_pprot          (pprot),
        .o_pwdata         (pwdata),
        .o_pstrb          (pstrb),
        .i_pready         (pready),
        .i_prdata         (prdata),
        .i_pslverr        (pslverr)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    task automatic scramble();
        bus_addr  = 8'($urandom);
        bus_write = 1'($urandom);
        bus_wdata = $urandom;
        bus_strb  = 4'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            bus_valid = 1'b0;
            pready    = 1'b0;
            pslverr   = 1'($urandom);
            prdata    = $urandom;
            sample();
            chk("idle_psel", 32'(psel), 32'd0);
            chk("idle_ready", 32'(bus_ready), 32'd0);
        end
    endtask

    // One bus transaction; waits = wait states the completer would insert.
    task automatic xfer(input logic [7:0] a, input logic w,
                        input logic [31:0] d, input logic [3:0] s,
                        input int waits, input bit err);
        bit          timed_out;
        int          n_access;
        logic [1:0]  exp_status;
        logic [31:0] exp_rdata;
        logic        last;
`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
        timed_out = (waits > TO - 1);
`else
        timed_out = 1'b0;
`endif
        n_access   = timed_out ? TO : waits + 1;
        exp_status = (timed_out || err) ? 2'b10 : 2'b00;
        exp_rdata  = timed_out ? ERRD : (w ? 32'd0 : ref_mem[a]);

        next_cycle();
        bus_valid = 1'b1;
        bus_addr  = a;
        bus_write = w;
        bus_wdata = d;
        bus_strb  = s;
        pready    = 1'b0;
        pslverr   = 1'($urandom);
        prdata    = $urandom;
        sample();
        chk("req_psel", 32'(psel), 32'd0);
        chk("req_ready", 32'(bus_ready), 32'd0);

        next_cycle();
        scramble();
        sample();
        chk("setup_psel", 32'(psel), 32'd1);
        chk("setup_penable", 32'(penable), 32'd0);
        chk("setup_paddr", 32'(paddr), 32'(a));
        chk("setup_pwrite", 32'(pwrite), 32'(w));
        chk("setup_pwdata", pwdata, w ? d : 32'd0);
        chk("setup_pstrb", 32'(pstrb), w ? 32'(s) : 32'd0);
        chk("setup_pprot", 32'(pprot), 32'(PP));
        chk("setup_ready", 32'(bus_ready), 32'd0);

        for (int k = 0; k < n_access; k++) begin
            next_cycle();
            last    = (k == n_access - 1);
            scramble();
            pready  = last && !timed_out;
            pslverr = pready ? err : 1'($urandom);
            prdata  = (pready && !pwrite) ? cpl_mem[paddr] : $urandom;
            sample();
            chk("acc_psel", 32'(psel), 32'd1);
            chk("acc_penable", 32'(penable), 32'd1);
            chk("acc_paddr", 32'(paddr), 32'(a));
            chk("acc_pwrite", 32'(pwrite), 32'(w));
            chk("acc_pwdata", pwdata, w ? d : 32'd0);
            chk("acc_pstrb", 32'(pstrb), w ? 32'(s) : 32'd0);
            chk("acc_ready", 32'(bus_ready), 32'(last));
            chk("acc_status", 32'(bus_status), last ? 32'(exp_status) : 32'd0);
            chk("acc_rdata", bus_rdata, last ? exp_rdata : 32'd0);
            if (pready && pwrite && !pslverr)
                cpl_mem[paddr] = merge(cpl_mem[paddr], pwdata, pstrb);
        end
        if (!timed_out && w && !err) ref_mem[a] = merge(ref_mem[a], d, s);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 32'(i) * 32'h0101_0101 ^ 32'hA5C3_0F96;
            cpl_mem[i] = ref_mem[i];
        end
        ref_mem[8'h20] = 32'h1234_5678;
        cpl_mem[8'h20] = 32'h1234_5678;

        #3;
        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_penable", 32'(penable), 32'd0);
        chk("rst_pwrite", 32'(pwrite), 32'd0);
        chk("rst_paddr", 32'(paddr), 32'd0);
        chk("rst_pwdata", pwdata, 32'd0);
        chk("rst_pstrb", 32'(pstrb), 32'd0);
        chk("rst_pprot", 32'(pprot), 32'(PP));
        next_cycle();
        rst_n = 1'b1;
        idle(2);

        xfer(8'h14, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, 1'b0);
        idle(1);
        xfer(8'h20, 1'b0, 32'h0, 4'h0, 3, 1'b0);
        idle(1);
        xfer(8'h14, 1'b0, 32'h0, 4'h0, 1, 1'b0);
        idle(1);
        xfer(8'h40, 1'b1, 32'h0BAD_F00D, 4'hF, 2, 1'b1);
        idle(1);
        xfer(8'h40, 1'b0, 32'h0, 4'h0, 0, 1'b0);
        xfer(8'h20, 1'b0, 32'h0, 4'h0, 1, 1'b0);
        xfer(8'h14, 1'b1, 32'h1122_3344, 4'b0101, 0, 1'b0);
        xfer(8'h14, 1'b0, 32'h0, 4'h0, 0, 1'b0);
        idle(1);

        // Reset in the middle of an ACCESS phase.
        next_cycle();
        bus_valid = 1'b1;
        bus_addr  = 8'h30;
        bus_write = 1'b1;
        bus_wdata = 32'hFFFF_FFFF;
        bus_strb  = 4'hF;
        next_cycle();
        next_cycle();
        pready = 1'b0;
        sample();
        chk("pre_rst_penable", 32'(penable), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_psel", 32'(psel), 32'd0);
        chk("arst_penable", 32'(penable), 32'd0);
        chk("arst_pstrb", 32'(pstrb), 32'd0);
        chk("arst_ready", 32'(bus_ready), 32'd0);
        bus_valid = 1'b0;
        next_cycle();
        sample();
        chk("rst_hold_ready", 32'(bus_ready), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        idle(1);
        xfer(8'h30, 1'b0, 32'h0, 4'h0, 1, 1'b0);
        idle(1);

`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
        xfer(8'h24, 1'b0, 32'h0, 4'h0, 100, 1'b0);
        idle(1);
        xfer(8'h24, 1'b0, 32'h0, 4'h0, TO - 1, 1'b0);
        idle(1);
        xfer(8'h28, 1'b1, 32'hCAFE_0001, 4'hF, 100, 1'b0);
        xfer(8'h28, 1'b0, 32'h0, 4'h0, 0, 1'b0);
        idle(1);
`endif

        for (int n = 0; n < 60; n++) begin
            logic [7:0] a;
            a = {2'b00, 4'($urandom_range(0, 15)), 2'b00};
`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
            xfer(a, 1'($urandom), $urandom, 4'($urandom),
                 $urandom_range(0, 6), ($urandom_range(0, 7) == 0));
`else
            xfer(a, 1'($urandom), $urandom, 4'($urandom),
                 $urandom_range(0, 5), ($urandom_range(0, 7) == 0));
`endif
            idle($urandom_range(0, 2));
        end
        idle(1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
